// File: rtl/logic_unit_sched.sv
// logic_unit_sched: round-robin two-port scheduler for the shared 32-bit logic unit
// (OR, AND, NOT, NEGATE). The result is held in Z until the consumer accepts it.

module lu_or #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] z_o
);
    assign z_o = a_i | b_i;
endmodule

module lu_and #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] z_o
);
    assign z_o = a_i & b_i;
endmodule

module lu_not #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] z_o
);
    assign z_o = ~a_i;
endmodule

module lu_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] z_o
);
    // Two's complement wraps: NEG(0) = 0 and NEG(most negative) = itself.
    assign z_o = ~a_i + {{(WIDTH-1){1'b0}}, 1'b1};
endmodule

// state | meaning
// IDLE  | arbitrating; the granted requester sees ready
// EXEC  | latched operands run through the logic unit; result captured into Z
// RESP  | Z presented to the consumer until resp_ready
module logic_unit_sched #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id,
    output logic             resp_zero,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_NOT = 2'b10;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             zero_q, zero_d;
    logic             rid_q, rid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             grant0, grant1;
    logic             acc0, acc1;
    logic [WIDTH-1:0] or_z, and_z, not_z, neg_z;
    logic [WIDTH-1:0] mux_z;

    // On a tie the port that did not win last time gets the grant.
    assign grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = (state_q == IDLE) && grant0 && !clr;
    assign req1_ready = (state_q == IDLE) && grant1 && !clr;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;

    lu_or  #(.WIDTH(WIDTH)) u_or  (.a_i(a_q), .b_i(b_q), .z_o(or_z));
    lu_and #(.WIDTH(WIDTH)) u_and (.a_i(a_q), .b_i(b_q), .z_o(and_z));
    lu_not #(.WIDTH(WIDTH)) u_not (.a_i(a_q), .z_o(not_z));
    lu_neg #(.WIDTH(WIDTH)) u_neg (.a_i(a_q), .z_o(neg_z));

    always_comb begin
        case (op_q)
            OP_OR:   mux_z = or_z;
            OP_AND:  mux_z = and_z;
            OP_NOT:  mux_z = not_z;
            default: mux_z = neg_z;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        z_d          = z_q;
        zero_d       = zero_q;
        rid_d        = rid_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (acc0) begin
                    op_d         = req0_op;
                    a_d          = req0_a;
                    b_d          = req0_b;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = EXEC;
                end else if (acc1) begin
                    op_d         = req1_op;
                    a_d          = req1_a;
                    b_d          = req1_b;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                z_d     = mux_z;
                zero_d  = (mux_z == '0);
                rid_d   = id_q;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            z_q          <= '0;
            zero_q       <= 1'b0;
            rid_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            z_q          <= z_d;
            zero_q       <= zero_d;
            rid_q        <= rid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_data  = z_q;
    assign resp_id    = rid_q;
    assign resp_zero  = zero_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_logic_unit_sched.sv
// Scoreboard bench for logic_unit_sched: cycle-level reference model predicts
// grants and held outputs; a separate monitor pops expected responses.

module tb_logic_unit_sched;
    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [1:0]    req0_op = 2'b00, req1_op = 2'b00;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [W-1:0]  resp_data;
    logic          resp_id, resp_zero, busy;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    logic_unit_sched #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .clr(clr),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .resp_zero(resp_zero), .busy(busy), .op_count(op_count)
    );

    typedef struct packed {logic [1:0] op; logic [31:0] a; logic [31:0] b;} req_t;
    typedef struct packed {logic [31:0] data; logic id;} exp_t;

    req_t q0[$];
    req_t q1[$];
    exp_t sb[$];
    exp_t done[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [32:0] t;
        case (op)
            2'b00:   return a | b;
            2'b01:   return a & b;
            2'b10:   return 32'hFFFF_FFFF - a;
            default: begin
                t = 33'h1_0000_0000 - {1'b0, a};
                return t[31:0];
            end
        endcase
    endfunction

    // Drivers: each port offers the head of its queue until it is taken.
    logic hs0 = 1'b0, hs1 = 1'b0;
    always @(negedge clk) begin
        hs0 = req0_valid && req0_ready && !clr;
        hs1 = req1_valid && req1_ready && !clr;
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (hs0 && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                req0_valid = 1'b1;
                {req0_op, req0_a, req0_b} = q0[0];
            end else req0_valid = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (hs1 && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                req1_valid = 1'b1;
                {req1_op, req1_a, req1_b} = q1[0];
            end else req1_valid = 1'b0;
        end
    end

    // Reference model: age = edges since the in-flight op was accepted (0 = none).
    int          age    = 0;
    logic        m_last = 1'b1;
    int          m_cnt  = 0;
    logic [31:0] m_z    = '0;
    logic        m_id   = 1'b0;
    logic        m_zero = 1'b0;
    exp_t        m_pend;
    logic        m_r0, m_r1;

    always @(negedge clk) begin
        m_r0 = 1'b0;
        m_r1 = 1'b0;
        if (!clr && age == 0) begin
            if (req0_valid && req1_valid) begin
                if (m_last) m_r0 = 1'b1;
                else        m_r1 = 1'b1;
            end else if (req0_valid) m_r0 = 1'b1;
            else if (req1_valid)     m_r1 = 1'b1;
        end
        check("req0_ready", req0_ready, m_r0);
        check("req1_ready", req1_ready, m_r1);
        check("busy", busy, age > 0);
        check("resp_valid", resp_valid, age >= 2);
        check("resp_data", resp_data, m_z);
        check("resp_id", resp_id, m_id);
        check("resp_zero", resp_zero, m_zero);
        check("op_count", op_count, 32'(m_cnt));
        if (clr) begin
            age = 0; m_last = 1'b1; m_cnt = 0;
            m_z = '0; m_id = 1'b0; m_zero = 1'b0;
            sb.delete();
        end else if (age == 0) begin
            if (m_r0 || m_r1) begin
                m_pend.id   = m_r1;
                m_pend.data = m_r1 ? ref_op(req1_op, req1_a, req1_b)
                                   : ref_op(req0_op, req0_a, req0_b);
                sb.push_back(m_pend);
                m_last = m_r1;
                age    = 1;
            end
        end else if (age == 1) begin
            age    = 2;
            m_z    = m_pend.data;
            m_id   = m_pend.id;
            m_zero = (m_pend.data == 32'h0);
        end else if (resp_ready) begin
            age = 0;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
    end

    // Monitor: compares each presented response with the scoreboard head.
    always @(negedge clk) begin
        if (!clr && resp_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_head: response %h presented, none expected at %0t",
                         resp_data, $time);
            end else begin
                check("sb_data", resp_data, sb[0].data);
                check("sb_id", resp_id, sb[0].id);
                check("sb_zero", resp_zero, sb[0].data == 32'h0);
                if (resp_ready) begin
                    void'(sb.pop_front());
                    done.push_back(exp_t'{resp_data, resp_id});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (k < budget && !(age == 0 && q0.size() == 0 && q1.size() == 0)) begin
            tick(1);
            k++;
        end
        n_checks++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic expect_done(input string name, input logic [31:0] d, input logic id);
        exp_t r;
        if (done.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no response completed, required %h", name, d);
        end else begin
            r = done.pop_front();
            check(name, r.data, d);
            check(name, r.id, id);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset with a request already pending: ready must stay low under clr.
        q0.push_back(req_t'{2'b00, 32'h0000_F0F0, 32'h0F0F_0000});
        tick(3);
        clr = 1'b0;
        wait_idle(20);
        expect_done("t1_or", 32'h0F0F_F0F0, 1'b0);
        check("t1_count", op_count, 32'd1);

        // Tie on both ports from reset: grants alternate 0,1,0,1.
        clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            q0.push_back(req_t'{2'b01, 32'hFFFF_0000, 32'h00FF_FF00});
            q1.push_back(req_t'{2'b10, 32'hFFFF_FFFF, 32'h1234_5678});
        end
        tick(2);
        clr = 1'b0;
        wait_idle(40);
        for (int i = 0; i < 2; i++) begin
            expect_done("t2_and", 32'h00FF_0000, 1'b0);
            expect_done("t2_not", 32'h0000_0000, 1'b1);
        end
        check("t2_count", op_count, 32'd4);

        // NEGATE boundaries.
        q1.push_back(req_t'{2'b11, 32'h0000_0001, 32'hDEAD_BEEF});
        q1.push_back(req_t'{2'b11, 32'h8000_0000, 32'h0});
        q1.push_back(req_t'{2'b11, 32'h0000_0000, 32'hFFFF_FFFF});
        wait_idle(40);
        expect_done("t3_neg1", 32'hFFFF_FFFF, 1'b1);
        expect_done("t3_negmin", 32'h8000_0000, 1'b1);
        expect_done("t3_neg0", 32'h0000_0000, 1'b1);

        // Consumer stalls in RESP while port 1 waits.
        resp_ready = 1'b0;
        q0.push_back(req_t'{2'b00, 32'h1234_5678, 32'h0});
        k = 0;
        while (age < 2 && k < 20) begin
            tick(1);
            k++;
        end
        check("t4_reach_resp", age >= 2, 1'b1);
        q1.push_back(req_t'{2'b01, 32'hFFFF_0000, 32'h0F0F_0F0F});
        tick(10);
        resp_ready = 1'b1;
        wait_idle(30);
        expect_done("t4_held", 32'h1234_5678, 1'b0);
        expect_done("t4_p1", 32'h0F0F_0000, 1'b1);

        // clr during EXEC discards the op; following tie goes to port 0.
        clr = 1'b1;
        q0.push_back(req_t'{2'b00, 32'h1, 32'h2});
        q1.push_back(req_t'{2'b00, 32'h4, 32'h8});
        tick(2);
        clr = 1'b0;
        k = 0;
        while (!busy && k < 20) begin
            tick(1);
            k++;
        end
        check("t5_accept", busy, 1'b1);
        clr = 1'b1;
        q0.push_back(req_t'{2'b01, 32'h0000_00F0, 32'h0000_00FF});
        tick(1);
        clr = 1'b0;
        check("t5_count_zero", op_count, 32'd0);
        check("t5_valid_low", resp_valid, 1'b0);
        wait_idle(40);
        expect_done("t5_tie_p0", 32'h0000_00F0, 1'b0);
        expect_done("t5_p1", 32'h0000_000C, 1'b1);
        check("t5_no_extra", done.size(), 32'd0);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 2)
                q0.push_back(req_t'{2'($urandom_range(0, 3)),
                                    ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom,
                                    $urandom});
            if ($urandom_range(0, 2) == 0 && q1.size() < 2)
                q1.push_back(req_t'{2'($urandom_range(0, 3)),
                                    ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
                                    $urandom});
            resp_ready = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        resp_ready = 1'b1;
        wait_idle(200);
        done.delete();

        // Enough completions since the last clr to saturate the counter.
        for (int i = 0; i < 16; i++)
            q0.push_back(req_t'{2'b00, $urandom, $urandom});
        wait_idle(100);
        check("sat_count", op_count, 32'h0000_000F);
        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/logic_unit_sched.md
# logic_unit_sched

Sequencer and two-port arbiter for the shared 32-bit logic unit (OR, AND, NOT, two's-complement NEGATE) in the CPU datapath. It accepts operation requests from two requesters (port 0: control-unit path, port 1: auxiliary/test path) over valid/ready handshakes. Requests are granted round-robin; operands are latched into A/B registers, the selected operation is run through the existing logic-op modules, and the result is held in a Z register until the consumer accepts it. It also keeps a count of completed operations for debug.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- CNT_W, 16, width of the completed-operation counter.

- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  scheduler accepts requester 0 this cycle.
- req0_op  in  2  operation code: 00 OR, 01 AND, 10 NOT, 11 NEGATE.
- req0_a  in  WIDTH  operand A.
- req0_b  in  WIDTH  operand B; ignored for NOT and NEGATE.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as the port 0 signals, for requester 1.
- resp_valid  out  1  Z holds a result.
- resp_ready  in  1  consumer takes the result.
- resp_data  out  WIDTH  result (Z register).
- resp_id  out  1  requester that issued the result.
- resp_zero  out  1  resp_data == 0.
- busy  out  1  state != IDLE.
- op_count  out  CNT_W  number of completed responses; saturates at all-ones.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: the arbiter picks one requester.
  - Only one valid: grant that requester.
  - Both valid: grant the requester that is not `last_grant`.
  - `reqN_ready` = (state == IDLE) && grantN. It is combinational from the valids and `last_grant`, and never high for both ports.
- Acceptance: on an edge where reqN_valid && reqN_ready:
  - latch op, a and b into internal registers;
  - set `id` = N and `last_grant` = N;
  - go to EXEC.
- EXEC: the latched operands drive the four logic-op instances. The mux output selected by op is registered into Z, the zero flag is registered, and the FSM goes to RESP.
- Operation results:
  - NOT returns ~a.
  - NEGATE returns ~a + 1 modulo 2^32: NEG(0) = 0 and NEG(0x80000000) = 0x80000000.
  - B is never used for ops 10 and 11.
- RESP: resp_valid = 1; resp_data, resp_id and resp_zero are held stable.
  - On an edge with resp_ready = 1: go to IDLE and increment op_count (no increment once it is all-ones).
  - While resp_ready = 0: stay in RESP indefinitely and hold every output.
- Requests arriving outside IDLE see ready = 0 and must hold their valid and payload (standard valid/ready; no drop).
- Request inputs are ignored outside IDLE.

## Timing
- Reset values: state IDLE, last_grant = 1 (so port 0 wins the first tie), resp_valid = 0, resp_data = 0, resp_id = 0, resp_zero = 0, busy = 0, op_count = 0, both reqN_ready = 0 while clr = 1.
- clr dominates all other inputs on any edge. Asserting it in EXEC or RESP discards the in-flight operation without counting it and returns to the reset values on the next edge.
- Latency:
  - accept at edge k;
  - EXEC during cycle k to k+1;
  - Z registered and resp_valid = 1 after edge k+1.
- Cycle usage: IDLE is re-entered one edge after the response handshake. The next accept happens at the earliest one edge later, so back-to-back operations take 3 cycles when resp_ready is held high.
- A response handshake and a new request in the same cycle: the request is not accepted that cycle (ready is 0 in RESP).
- resp_zero and resp_data change only on the EXEC→RESP edge and at reset.
- op_count is updated on the RESP→IDLE edge only.

## Test plan
- Reset, then a port 0 OR request with a = 0x0000_F0F0, b = 0x0F0F_0000 and resp_ready = 1:
  - req0_ready high in the first cycle;
  - resp_valid high 2 edges after accept, with resp_data = 0x0F0F_F0F0, resp_id = 0, resp_zero = 0;
  - op_count = 1 after the handshake.
- Both ports valid continuously (port 0 AND 0xFFFF_0000 & 0x00FF_FF00; port 1 NOT of 0xFFFF_FFFF):
  - grants alternate 0, 1, 0, 1;
  - results 0x00FF_0000 and 0x0000_0000 (the latter with resp_zero = 1);
  - one accept every 3 cycles.
- NEGATE results:
  - a = 0x0000_0001, b = 0xDEAD_BEEF gives 0xFFFF_FFFF;
  - a = 0x8000_0000 gives 0x8000_0000;
  - a = 0 gives 0 with resp_zero = 1.
- Hold resp_ready = 0 for 10 cycles in RESP with port 1 valid:
  - resp_data and resp_id stay stable;
  - req1_ready stays 0;
  - busy stays 1;
  - port 1 is accepted exactly one edge after resp_ready rises and IDLE is entered.
- Assert clr for one cycle while in EXEC: resp_valid never rises, op_count is unchanged (0), all outputs return to their reset values, and a subsequent tie grants port 0.
- Preload op_count near all-ones (run 2^CNT_W completions, or use CNT_W = 2 in the bench): the counter sticks at all-ones.
